std_mem_copy_d1: RTL and testbench

- Initiator-side engine for the single-port 1-D memory interface (addr0 / read_data / write_data / write_en / done).
- On a go/done handshake, copies len words from a source memory (combinational read port) to a destination memory, one word per write/done exchange.
- Sits between two memory instances inside generated components, replacing hand-written copy loops.

---
 rtl/std_mem_copy_pkg.sv | 15 +
 rtl/std_mem_copy_d1_if.sv | 28 ++
 rtl/std_mem_copy_d1.sv | 118 +++++++++++
 tb/tb_std_mem_copy_d1.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/std_mem_copy_pkg.sv
// Shared types for the 1-D memory copy engine: FSM state encoding.
package std_mem_copy_pkg;

  localparam int unsigned STATE_W = 3;

  // READ is only reachable when STD_MEM_COPY_REG_READ_EN is defined.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/std_mem_copy_d1_if.sv
// Bus bundle of the copy engine: go/len/done control plus source and destination memory ports.
interface std_mem_copy_d1_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_SIZE = 4
);

  logic                go;
  logic [IDX_SIZE:0]   len;
  logic                done;
  logic [IDX_SIZE-1:0] src_addr0;
  logic [WIDTH-1:0]    src_read_data;
  logic [IDX_SIZE-1:0] dst_addr0;
  logic [WIDTH-1:0]    dst_write_data;
  logic                dst_write_en;
  logic                dst_done;

  // master: the copy engine; slave: controller and memories around it
  modport master (
    input  go, len, src_read_data, dst_done,
    output done, src_addr0, dst_addr0, dst_write_data, dst_write_en
  );

  modport slave (
    output go, len, src_read_data, dst_done,
    input  done, src_addr0, dst_addr0, dst_write_data, dst_write_en
  );

endinterface

// File: rtl/std_mem_copy_d1.sv
// Copies len words from a combinational-read source memory to a destination memory.
// Define STD_MEM_COPY_REG_READ_EN to register source data in a READ state before each write.
module std_mem_copy_d1
  import std_mem_copy_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  std_mem_copy_d1_if.master bus
);

  localparam int unsigned LEN_W = IDX_SIZE + 1;

`ifdef STD_MEM_COPY_REG_READ_EN
  localparam state_e FIRST_ST = READ;
`else
  localparam state_e FIRST_ST = WRITE;
`endif

  state_e              state_q, state_d;
  logic [IDX_SIZE-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    len_clamped;
  logic                last_idx;
  logic [WIDTH-1:0]    wr_data;

  assign len_clamped = (bus.len > LEN_W'(SIZE)) ? LEN_W'(SIZE) : bus.len;
  assign last_idx    = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

`ifdef STD_MEM_COPY_REG_READ_EN
  logic [WIDTH-1:0] data_q, data_d;

  assign data_d  = (state_q == READ) ? bus.src_read_data : data_q;
  assign wr_data = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end
`else
  assign wr_data = bus.src_read_data;
`endif

  // State, index and latched length registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  // Next-state and index/length update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          len_d   = len_clamped;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? FIN : FIRST_ST;
        end
      end
`ifdef STD_MEM_COPY_REG_READ_EN
      READ:  state_d = WRITE;
`endif
      WRITE: state_d = WAIT;
      WAIT: begin
        if (bus.dst_done) begin
          if (last_idx) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_SIZE'(1);
            state_d = FIRST_ST;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; source data reaches the destination only in WRITE
  always_comb begin
    bus.done           = 1'b0;
    bus.dst_write_en   = 1'b0;
    bus.src_addr0      = '0;
    bus.dst_addr0      = '0;
    bus.dst_write_data = '0;
    case (state_q)
`ifdef STD_MEM_COPY_REG_READ_EN
      READ: bus.src_addr0 = idx_q;
`endif
      WRITE: begin
        bus.src_addr0      = idx_q;
        bus.dst_addr0      = idx_q;
        bus.dst_write_en   = 1'b1;
        bus.dst_write_data = wr_data;
      end
      WAIT: begin
        bus.src_addr0 = idx_q;
        bus.dst_addr0 = idx_q;
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_std_mem_copy_d1.sv
// Bench for std_mem_copy_d1: directed and random copies against an array model of both memories.
module tb_std_mem_copy_d1;

`ifdef STD_MEM_COPY_REG_READ_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;
  int   dly = 1;
  logic clr;
  logic extra_done;

  logic [31:0] smem [16];
  logic [31:0] dmem [16];
  logic [31:0] exp_dst [16];
  int          cnt;

  int          strb_cyc [$];
  logic [3:0]  strb_addr [$];
  logic [3:0]  strb_saddr [$];
  logic [31:0] strb_data [$];
  int          done_cyc [$];

  std_mem_copy_d1_if #(.WIDTH(32), .IDX_SIZE(4)) bus ();

  std_mem_copy_d1 #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.src_read_data = smem[bus.src_addr0];
  assign bus.dst_done      = (cnt == 1) || extra_done;

  // Destination memory: write on strobe, acknowledge dly cycles later
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'hDEAD_0000 | 32'(i);
      cnt <= 0;
    end else if (reset) begin
      cnt <= 0;
    end else if (bus.dst_write_en) begin
      dmem[bus.dst_addr0] <= bus.dst_write_data;
      cnt <= dly;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dst_write_en) begin
        strb_cyc.push_back(cyc - base + 1);
        strb_addr.push_back(bus.dst_addr0);
        strb_saddr.push_back(bus.src_addr0);
        strb_data.push_back(bus.dst_write_data);
      end
      if (bus.done) done_cyc.push_back(cyc - base + 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    strb_cyc.delete(); strb_addr.delete(); strb_saddr.delete();
    strb_data.delete(); done_cyc.delete();
  endtask

  task automatic rand_src();
    for (int i = 0; i < 16; i++) smem[i] = $urandom;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s dst[%0d]", tag, i), 64'(dmem[i]), 64'(exp_dst[i]));
  endtask

  // One go pulse; expected timing: per-word period p, done at n*p+1
  task automatic run_xfer(input string tag, input int l, input int d);
    int n, p, t;
    n = (l > 16) ? 16 : l;
    p = 1 + d + R;
    dly = d;
    @(posedge clk); #1;
    clear_mon();
    bus.go  = 1'b1;
    bus.len = 5'(l);
    @(posedge clk); #1;
    base    = cyc;
    bus.go  = 1'b0;
    bus.len = 5'($urandom);
    t = 0;
    while (done_cyc.size() == 0 && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check({tag, " done_count"}, 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) check({tag, " done_cycle"}, 64'(done_cyc[0]), 64'(n * p + 1));
    check({tag, " strobe_count"}, 64'(strb_cyc.size()), 64'(n));
    for (int i = 0; i < n && i < strb_cyc.size(); i++) begin
      check($sformatf("%s strobe%0d cycle", tag, i), 64'(strb_cyc[i]), 64'(R + 1 + i * p));
      check($sformatf("%s strobe%0d addr", tag, i), 64'(strb_addr[i]), 64'(i));
      check($sformatf("%s strobe%0d saddr", tag, i), 64'(strb_saddr[i]), 64'(i));
      check($sformatf("%s strobe%0d data", tag, i), 64'(strb_data[i]), 64'(smem[i]));
    end
    for (int i = 0; i < n; i++) exp_dst[i] = smem[i];
    check_mem(tag);
  endtask

  initial begin
    int t, p, target;
    reset = 1'b1; clr = 1'b1; extra_done = 1'b0;
    bus.go = 1'b0; bus.len = '0;
    for (int i = 0; i < 16; i++) exp_dst[i] = 32'hDEAD_0000 | 32'(i);
    rand_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst we", 64'(bus.dst_write_en), 64'd0);
    check("rst src_addr", 64'(bus.src_addr0), 64'd0);
    check("rst dst_addr", 64'(bus.dst_addr0), 64'd0);
    check("rst wdata", 64'(bus.dst_write_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; clr = 1'b0;

    smem[0] = 32'hA; smem[1] = 32'hB; smem[2] = 32'hC; smem[3] = 32'hD;
    run_xfer("len4", 4, 1);
    run_xfer("len0", 0, 1);
    rand_src();
    run_xfer("len20", 20, 1);
    rand_src();
    run_xfer("len4_slow", 4, 3);

    // Acknowledge outside WAIT must not start anything
    @(posedge clk); #1;
    clear_mon();
    extra_done = 1'b1;
    repeat (4) @(negedge clk);
    extra_done = 1'b0;
    check("stray_ack strobes", 64'(strb_cyc.size()), 64'd0);
    check("stray_ack done", 64'(done_cyc.size()), 64'd0);

    // Reset during the third WAIT of an 8-word copy
    rand_src();
    dly = 1;
    p = 2 + R;
    target = R + 1 + 2 * p + 1;
    @(posedge clk); #1;
    clear_mon();
    bus.go = 1'b1; bus.len = 5'd8;
    @(posedge clk); #1;
    base = cyc; bus.go = 1'b0;
    t = 0;
    while ((cyc - base + 1) != target && t < 100) begin @(negedge clk); t++; end
    check("midrst strobes_before", 64'(strb_cyc.size()), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("midrst we", 64'(bus.dst_write_en), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst addr", 64'(bus.dst_addr0), 64'd0);
    check("midrst wdata", 64'(bus.dst_write_data), 64'd0);
    for (int i = 0; i < 3; i++) exp_dst[i] = smem[i];
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    check("postrst strobes", 64'(strb_cyc.size()), 64'd0);
    check("postrst done", 64'(done_cyc.size()), 64'd0);
    check_mem("postrst");
    rand_src();
    run_xfer("after_rst len2", 2, 1);

    // go held high: back-to-back single-word transfers
    rand_src();
    dly = 1;
    p = 2 + R;
    @(posedge clk); #1;
    clear_mon();
    bus.go = 1'b1; bus.len = 5'd1;
    @(posedge clk); #1;
    base = cyc;
    t = 0;
    while (done_cyc.size() < 3 && t < 100) begin @(negedge clk); t++; end
    bus.go = 1'b0;
    repeat (5) @(negedge clk);
    check("hold done_count", 64'(done_cyc.size()), 64'd3);
    for (int j = 0; j < 3 && j < done_cyc.size(); j++)
      check($sformatf("hold done%0d cycle", j), 64'(done_cyc[j]), 64'(p + 1 + j * (p + 2)));
    check("hold strobes", 64'(strb_cyc.size()), 64'd3);
    exp_dst[0] = smem[0];
    check_mem("hold");

    repeat (6) begin
      int l, d;
      rand_src();
      l = $urandom_range(0, 20);
      d = $urandom_range(1, 3);
      run_xfer($sformatf("rand len%0d d%0d", l, d), l, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
